// File: rtl/wave_fetch_arbiter.sv
// Round-robin arbiter sharing one fixed-latency SDRAM read port among sample voices.
// Each grant issues a one-cycle mem_rd, then returns mem_dout with a one-hot ack.
module wave_fetch_arbiter #(
    parameter int VOICES  = 4,
    parameter int ADDR_W  = 25,
    parameter int LATENCY = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [VOICES-1:0]        voice_req,
    input  logic [VOICES*ADDR_W-1:0] voice_addr,
    output logic [VOICES-1:0]        voice_ack,
    output logic [15:0]              voice_data,
    input  logic                     dl_busy,
    input  logic                     PAUSED,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [15:0]              mem_dout,
    output logic                     busy
);

    localparam int PW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int CW = 4;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state_q;
    logic [PW-1:0]       ptr_q;
    logic [CW-1:0]       cnt_q;
    logic                mem_rd_q;
    logic                busy_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [VOICES-1:0]   ack_q;
    logic [15:0]         data_q;

    logic [VOICES-1:0]   eligible_d;
    logic                found_d;
    logic [PW-1:0]       sel_d;
    logic [ADDR_W-1:0]   sel_addr_d;
    int                  rr_idx;

    // A voice being acked this cycle still holds req high; mask it so it is not re-granted.
    always_comb begin
        eligible_d = voice_req & ~ack_q;
        found_d    = 1'b0;
        sel_d      = ptr_q;
        rr_idx     = 0;
        for (int k = 1; k <= VOICES; k++) begin
            rr_idx = (int'(ptr_q) + k) % VOICES;
            if (!found_d && eligible_d[rr_idx]) begin
                found_d = 1'b1;
                sel_d   = PW'(rr_idx);
            end
        end
        sel_addr_d = voice_addr[int'(sel_d)*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            ptr_q      <= PW'(VOICES - 1);
            cnt_q      <= '0;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            mem_addr_q <= '0;
            ack_q      <= '0;
            data_q     <= '0;
        end else begin
            mem_rd_q <= 1'b0;
            ack_q    <= '0;
            case (state_q)
                S_IDLE: begin
                    if (found_d && !dl_busy && !PAUSED) begin
                        state_q    <= S_WAIT;
                        ptr_q      <= sel_d;
                        cnt_q      <= CW'(LATENCY - 1);
                        mem_rd_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        mem_addr_q <= sel_addr_d & {{(ADDR_W-1){1'b1}}, 1'b0};
                    end
                end
                S_WAIT: begin
                    // Blocking inputs are ignored here so an issued read always completes.
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        data_q  <= mem_dout;
                        ack_q   <= VOICES'(1) << ptr_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign voice_ack  = ack_q;
    assign voice_data = data_q;
    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_wave_fetch_arbiter.sv
// Bench for wave_fetch_arbiter: directed scenarios plus a randomized run, all checked
// against a timestamp-based transaction model of the arbiter.
module tb_wave_fetch_arbiter;

    localparam int V  = 4;
    localparam int AW = 25;
    localparam int L  = 4;

    logic            CLK = 1'b0;
    logic            RESET = 1'b0;
    logic [V-1:0]    voice_req;
    logic [V*AW-1:0] voice_addr;
    logic [V-1:0]    voice_ack;
    logic [15:0]     voice_data;
    logic            dl_busy;
    logic            PAUSED;
    logic            mem_rd;
    logic [AW-1:0]   mem_addr;
    logic [15:0]     mem_dout;
    logic            busy;

    always #5 CLK = ~CLK;

    wave_fetch_arbiter #(.VOICES(V), .ADDR_W(AW), .LATENCY(L)) dut (
        .CLK(CLK), .RESET(RESET),
        .voice_req(voice_req), .voice_addr(voice_addr),
        .voice_ack(voice_ack), .voice_data(voice_data),
        .dl_busy(dl_busy), .PAUSED(PAUSED),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .busy(busy)
    );

    int checks = 0;
    int passes = 0;

    // Model: one outstanding read, described by its issue cycle and granted voice.
    int            cyc;
    int            m_ptr;
    bit            m_inflight;
    int            m_trd;
    int            m_g;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_data;
    logic [V-1:0]  exp_ack;

    int rd_cyc[$];
    int rd_adr[$];
    int ack_cyc[$];
    int ack_val[$];
    int busy_hi;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int at_i(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [AW-1:0] vaddr(int i);
        return AW'(i * 32'h1000 + 32'h10);
    endfunction

    task automatic set_addr(int i, logic [AW-1:0] a);
        voice_addr[i*AW +: AW] = a;
    endtask

    task automatic clr_logs();
        rd_cyc.delete(); rd_adr.delete(); ack_cyc.delete(); ack_val.delete();
        busy_hi = 0;
    endtask

    task automatic check_cycle();
        logic exp_rd, exp_busy;
        exp_rd   = m_inflight && (cyc == m_trd);
        exp_busy = m_inflight && (cyc >= m_trd) && (cyc <= m_trd + L - 1);
        exp_ack  = '0;
        if (m_inflight && cyc == m_trd + L) exp_ack[m_g] = 1'b1;
        chk("mem_rd",     32'(mem_rd),     32'(exp_rd));
        chk("busy",       32'(busy),       32'(exp_busy));
        chk("voice_ack",  32'(voice_ack),  32'(exp_ack));
        chk("voice_data", 32'(voice_data), 32'(m_data));
        chk("mem_addr",   32'(mem_addr),   32'(m_addr));
        if (mem_rd) begin rd_cyc.push_back(cyc); rd_adr.push_back(int'(mem_addr)); end
        if (voice_ack != '0) begin ack_cyc.push_back(cyc); ack_val.push_back(int'(voice_ack)); end
        if (busy) busy_hi++;
        if (exp_ack != '0) m_inflight = 1'b0;
    endtask

    // Apply the model's decision for the inputs of the current cycle, then advance one cycle.
    task automatic step();
        if (m_inflight && cyc == m_trd + L - 1) m_data = mem_dout;
        if (!m_inflight && !dl_busy && !PAUSED) begin
            for (int k = 1; k <= V; k++) begin
                int v;
                v = (m_ptr + k) % V;
                if (voice_req[v] && !exp_ack[v]) begin
                    m_ptr = v; m_g = v; m_inflight = 1'b1; m_trd = cyc + 1;
                    m_addr = voice_addr[v*AW +: AW];
                    m_addr[0] = 1'b0;
                    break;
                end
            end
        end
        @(posedge CLK); #1;
        cyc++;
        check_cycle();
    endtask

    task automatic do_reset();
        RESET = 1'b1; #1;
        chk("rst_mem_rd",     32'(mem_rd),     32'h0);
        chk("rst_mem_addr",   32'(mem_addr),   32'h0);
        chk("rst_voice_ack",  32'(voice_ack),  32'h0);
        chk("rst_voice_data", 32'(voice_data), 32'h0);
        chk("rst_busy",       32'(busy),       32'h0);
        m_ptr = V - 1; m_inflight = 1'b0; m_trd = -100; m_g = 0;
        m_addr = '0; m_data = '0; exp_ack = '0;
        repeat (2) @(posedge CLK);
        #2 RESET = 1'b0;
        cyc = 0;
        check_cycle();
    endtask

    initial begin
        int guard, x;
        bit hold;
        voice_req = '0; voice_addr = '0; dl_busy = 1'b0; PAUSED = 1'b0; mem_dout = '0;
        #2;
        do_reset();

        // Single request from voice 2
        clr_logs();
        set_addr(2, 25'h000123); voice_req = 4'b0100; mem_dout = 16'hBEEF;
        repeat (12) begin step(); if (exp_ack[2]) voice_req[2] = 1'b0; end
        chk("A_rd_count",  32'(rd_cyc.size()), 32'd1);
        chk("A_rd_addr",   32'(at_i(rd_adr, 0)), 32'h000122);
        chk("A_ack_val",   32'(at_i(ack_val, 0)), 32'b0100);
        chk("A_ack_delay", 32'(at_i(ack_cyc, 0) - at_i(rd_cyc, 0)), 32'(L));
        chk("A_data",      32'(voice_data), 32'hBEEF);

        // All voices requesting continuously from reset
        do_reset();
        clr_logs();
        for (int i = 0; i < V; i++) set_addr(i, vaddr(i));
        voice_req = '1;
        repeat (30) step();
        for (int k = 0; k < 5; k++)
            chk($sformatf("B_grant%0d", k), 32'(at_i(rd_adr, k)), 32'(vaddr(k % V)));
        for (int k = 0; k < 4; k++)
            chk($sformatf("B_gap%0d", k), 32'(at_i(rd_cyc, k + 1) - at_i(rd_cyc, k)), 32'(L + 1));
        for (int k = 1; k < rd_adr.size(); k++)
            chk("B_norepeat", 32'(rd_adr[k] != rd_adr[k-1]), 32'd1);
        voice_req = '0;
        repeat (8) step();

        // Voice 1 holds req exactly one cycle past its ack
        clr_logs();
        voice_req = 4'b0010; hold = 1'b0;
        repeat (14) begin
            step();
            if (hold) begin voice_req[1] = 1'b0; hold = 1'b0; end
            if (exp_ack[1]) hold = 1'b1;
        end
        chk("C_rd_count", 32'(rd_cyc.size()), 32'd1);
        clr_logs();
        voice_req = 4'b0010;
        repeat (14) step();
        chk("C_regrant_gap", 32'(at_i(rd_cyc, 1) - at_i(ack_cyc, 0)), 32'd2);
        voice_req = '0;
        repeat (8) step();

        // dl_busy raised in the cycle after mem_rd
        clr_logs();
        voice_req = 4'b1001;
        guard = 0;
        do begin step(); guard++; end while (!mem_rd && guard < 10);
        chk("D_rd_seen", 32'(mem_rd), 32'd1);
        step();
        dl_busy = 1'b1;
        repeat (15) begin step(); voice_req = voice_req & ~exp_ack; end
        chk("D_rd_during",  32'(rd_cyc.size()),  32'd1);
        chk("D_ack_during", 32'(ack_cyc.size()), 32'd1);
        dl_busy = 1'b0;
        x = cyc;
        step();
        chk("D_resume", 32'(mem_rd), 32'd1);
        chk("D_resume_cycle", 32'(cyc), 32'(x + 1));
        repeat (10) begin step(); voice_req = voice_req & ~exp_ack; end

        // PAUSED for 100 cycles with all voices pending
        clr_logs();
        PAUSED = 1'b1; voice_req = '1;
        repeat (100) step();
        chk("E_rd_count", 32'(rd_cyc.size()), 32'd0);
        chk("E_busy_cycles", 32'(busy_hi), 32'd0);
        x = (m_ptr + 1) % V;
        PAUSED = 1'b0;
        step();
        chk("E_rd_release", 32'(mem_rd), 32'd1);
        chk("E_first_grant", 32'(mem_addr), 32'(vaddr(x)));

        // Reset two cycles into WAIT
        step();
        voice_req = '0;
        do_reset();
        clr_logs();
        repeat (10) step();
        chk("F_no_ack", 32'(ack_cyc.size()), 32'd0);
        voice_req = '1;
        guard = 0;
        do begin step(); guard++; end while (!mem_rd && guard < 10);
        chk("F_first_grant", 32'(mem_addr), 32'(vaddr(0)));

        // Randomized traffic
        repeat (400) begin
            step();
            for (int i = 0; i < V; i++) begin
                if (exp_ack[i]) begin
                    if ($urandom_range(3) != 0) voice_req[i] = 1'b0;
                end else if (!voice_req[i] && $urandom_range(2) == 0) begin
                    set_addr(i, AW'($urandom));
                    voice_req[i] = 1'b1;
                end else if ($urandom_range(15) == 0) begin
                    set_addr(i, AW'($urandom));
                end
            end
            dl_busy  = ($urandom_range(9) == 0);
            PAUSED   = ($urandom_range(11) == 0);
            mem_dout = 16'($urandom);
        end
        voice_req = '0; dl_busy = 1'b0; PAUSED = 1'b0;
        repeat (10) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
